// File: rtl/ste_microwire_rx.sv
// STE microwire receiver: synchronises the DMA-sound microwire stream, decodes
// LMC1992 commands into the audio control registers and derives channel attenuation.
module ste_microwire_rx #(
    parameter int unsigned SLOT_LEN  = 32,
    parameter int unsigned SAMPLE_PH = 15
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       mw_clk,
    input  logic       mw_data,
    input  logic       mw_done,
    output logic [5:0] master_vol,
    output logic [4:0] left_vol,
    output logic [4:0] right_vol,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic [1:0] mix,
    output logic [5:0] atten_l,
    output logic [5:0] atten_r,
    output logic       cmd_valid,
    output logic       cmd_err
);
    localparam int unsigned PH_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned SR_W  = 11;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DECODE
    } state_e;

    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic [2:0]       done_sync_q;
    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [5:0]       master_q, master_d;
    logic [4:0]       left_q, left_d;
    logic [4:0]       right_q, right_d;
    logic [3:0]       bass_q, bass_d;
    logic [3:0]       treble_q, treble_d;
    logic [1:0]       mix_q, mix_d;
    logic [5:0]       atten_l_q, atten_l_d;
    logic [5:0]       atten_r_q, atten_r_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             clk_rise_c, clk_fall_c, done_rise_c, cmd_ok_c;
    logic [6:0]       sum_l_c, sum_r_c;

    assign clk_rise_c  = clk_sync_q[1] & ~clk_sync_q[2];
    assign clk_fall_c  = ~clk_sync_q[1] & clk_sync_q[2];
    assign done_rise_c = done_sync_q[1] & ~done_sync_q[2];

    // Next-state, deserialiser and command decode
    always_comb begin
        state_d   = state_q;
        phase_d   = (phase_q == PH_W'(SLOT_LEN - 1)) ? '0 : phase_q + PH_W'(1);
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        master_d  = master_q;
        left_d    = left_q;
        right_d   = right_q;
        bass_d    = bass_q;
        treble_d  = treble_q;
        mix_d     = mix_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cmd_ok_c  = 1'b0;

        if (clk_rise_c) begin
            phase_d = '0;
        end

        case (state_q)
            ST_IDLE:   if (clk_rise_c) state_d = ST_SHIFT;
            ST_SHIFT:  if (clk_fall_c) state_d = ST_GAP;
            ST_GAP:    if (clk_rise_c) state_d = ST_SHIFT;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (done_rise_c) begin
            state_d = ST_DECODE;
        end

        // A fresh transfer restarts framing; GAP->SHIFT keeps accumulating masked bits
        if (state_q == ST_IDLE && state_d == ST_SHIFT) begin
            cnt_d = '0;
            sr_d  = '0;
        end
        if (state_q == ST_DECODE) begin
            cnt_d = '0;
            sr_d  = '0;
        end
        if (state_q == ST_SHIFT && phase_q == PH_W'(SAMPLE_PH)) begin
            sr_d  = {sr_q[SR_W-2:0], data_sync_q[1]};
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end

        // Decode sees this cycle's sample, so a coincident sample point is not lost
        cmd_ok_c = (cnt_d == CNT_W'(SR_W)) && (sr_d[10:9] == 2'b10) && (sr_d[8:7] != 2'b11);
        if (done_rise_c) begin
            if (cmd_ok_c) begin
                valid_d = 1'b1;
                case (sr_d[8:6])
                    3'b011:  master_d = (sr_d[5:0] > 6'd40) ? 6'd40 : sr_d[5:0];
                    3'b101:  left_d   = (sr_d[5:0] > 6'd20) ? 5'd20 : sr_d[4:0];
                    3'b100:  right_d  = (sr_d[5:0] > 6'd20) ? 5'd20 : sr_d[4:0];
                    3'b010:  treble_d = (sr_d[5:0] > 6'd12) ? 4'd12 : sr_d[3:0];
                    3'b001:  bass_d   = (sr_d[5:0] > 6'd12) ? 4'd12 : sr_d[3:0];
                    default: mix_d    = sr_d[1:0];
                endcase
            end else begin
                err_d = 1'b1;
            end
        end

        sum_l_c   = (7'd40 - 7'(master_q)) + (7'd20 - 7'(left_q));
        sum_r_c   = (7'd40 - 7'(master_q)) + (7'd20 - 7'(right_q));
        atten_l_d = (sum_l_c > 7'd63) ? 6'd63 : sum_l_c[5:0];
        atten_r_d = (sum_r_c > 7'd63) ? 6'd63 : sum_r_c[5:0];
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            done_sync_q <= '0;
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            sr_q        <= '0;
            master_q    <= 6'd40;
            left_q      <= 5'd20;
            right_q     <= 5'd20;
            bass_q      <= 4'd6;
            treble_q    <= 4'd6;
            mix_q       <= 2'd1;
            atten_l_q   <= '0;
            atten_r_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], mw_clk};
            data_sync_q <= {data_sync_q[0], mw_data};
            done_sync_q <= {done_sync_q[1:0], mw_done};
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            master_q    <= master_d;
            left_q      <= left_d;
            right_q     <= right_d;
            bass_q      <= bass_d;
            treble_q    <= treble_d;
            mix_q       <= mix_d;
            atten_l_q   <= atten_l_d;
            atten_r_q   <= atten_r_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign master_vol = master_q;
    assign left_vol   = left_q;
    assign right_vol  = right_q;
    assign bass       = bass_q;
    assign treble     = treble_q;
    assign mix        = mix_q;
    assign atten_l    = atten_l_q;
    assign atten_r    = atten_r_q;
    assign cmd_valid  = valid_q;
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_ste_microwire_rx.sv
// Scoreboard bench for ste_microwire_rx: drives masked microwire transfers and
// checks register state, attenuation and pulses against a behavioural LMC1992 model.
`timescale 1ns/1ps
module tb_ste_microwire_rx;
    localparam int unsigned SLOT_LEN  = 32;
    localparam int unsigned SAMPLE_PH = 15;

    logic       clk32 = 1'b0;
    logic       reset = 1'b1;
    logic       mw_clk = 1'b0;
    logic       mw_data = 1'b0;
    logic       mw_done = 1'b0;
    logic [5:0] master_vol;
    logic [4:0] left_vol, right_vol;
    logic [3:0] bass, treble;
    logic [1:0] mix;
    logic [5:0] atten_l, atten_r;
    logic       cmd_valid, cmd_err;

    typedef struct {
        bit         err;
        logic [5:0] mv;
        logic [4:0] lv;
        logic [4:0] rv;
        logic [3:0] bs;
        logic [3:0] tr;
        logic [1:0] mx;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] m_mv = 6'd40;
    logic [4:0] m_lv = 5'd20;
    logic [4:0] m_rv = 5'd20;
    logic [3:0] m_bs = 4'd6;
    logic [3:0] m_tr = 4'd6;
    logic [1:0] m_mx = 2'd1;
    bit         atten_due = 1'b0;
    logic [5:0] exp_al, exp_ar;

    ste_microwire_rx #(.SLOT_LEN(SLOT_LEN), .SAMPLE_PH(SAMPLE_PH)) dut (
        .clk32      (clk32),
        .reset      (reset),
        .mw_clk     (mw_clk),
        .mw_data    (mw_data),
        .mw_done    (mw_done),
        .master_vol (master_vol),
        .left_vol   (left_vol),
        .right_vol  (right_vol),
        .bass       (bass),
        .treble     (treble),
        .mix        (mix),
        .atten_l    (atten_l),
        .atten_r    (atten_r),
        .cmd_valid  (cmd_valid),
        .cmd_err    (cmd_err)
    );

    always #5 clk32 = ~clk32;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    function automatic logic [5:0] model_atten(input logic [5:0] mv, input logic [4:0] vol);
        int s;
        s = (40 - int'(mv)) + (20 - int'(vol));
        return (s > 63) ? 6'd63 : 6'(s);
    endfunction

    task automatic model_reset();
        m_mv = 6'd40; m_lv = 5'd20; m_rv = 5'd20;
        m_bs = 4'd6;  m_tr = 4'd6;  m_mx = 2'd1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_master"}, 32'(master_vol), 32'd40);
        check_eq({tag, "_left"},   32'(left_vol),   32'd20);
        check_eq({tag, "_right"},  32'(right_vol),  32'd20);
        check_eq({tag, "_bass"},   32'(bass),       32'd6);
        check_eq({tag, "_treble"}, 32'(treble),     32'd6);
        check_eq({tag, "_mix"},    32'(mix),        32'd1);
        check_eq({tag, "_atten_l"}, 32'(atten_l),   32'd0);
        check_eq({tag, "_atten_r"}, 32'(atten_r),   32'd0);
        check_eq({tag, "_pulses"}, 32'({cmd_valid, cmd_err}), 32'd0);
    endtask

    // Master model: one SLOT_LEN slot per mask bit, clock strobe only where masked.
    // abort_at >= 0 asserts reset halfway through that masked bit and drops the transfer.
    task automatic send(input logic [15:0] data, input logic [15:0] mask, input int abort_at);
        int          nbits;
        logic [10:0] sr;
        exp_t        e;
        nbits = 0;
        sr    = '0;
        for (int i = 15; i >= 0; i--) begin
            mw_clk  = mask[i];
            mw_data = data[i] & mask[i];
            if (mask[i] && nbits == abort_at) begin
                repeat (SLOT_LEN / 2) tick();
                reset = 1'b1; mw_clk = 1'b0; mw_data = 1'b0;
                repeat (8) tick();
                model_reset();
                reset = 1'b0;
                tick();
                return;
            end
            repeat (SLOT_LEN) tick();
            if (mask[i]) begin
                nbits = (nbits < 15) ? nbits + 1 : 15;
                sr    = {sr[9:0], data[i]};
            end
        end
        mw_clk = 1'b0; mw_data = 1'b0;
        repeat (8) tick();

        e.err = !(nbits == 11 && sr[10:9] == 2'b10 && sr[8:7] != 2'b11);
        if (!e.err) begin
            case (sr[8:6])
                3'b011:  m_mv = (sr[5:0] > 6'd40) ? 6'd40 : sr[5:0];
                3'b101:  m_lv = (sr[5:0] > 6'd20) ? 5'd20 : sr[4:0];
                3'b100:  m_rv = (sr[5:0] > 6'd20) ? 5'd20 : sr[4:0];
                3'b010:  m_tr = (sr[5:0] > 6'd12) ? 4'd12 : sr[3:0];
                3'b001:  m_bs = (sr[5:0] > 6'd12) ? 4'd12 : sr[3:0];
                default: m_mx = sr[1:0];
            endcase
        end
        e.mv = m_mv; e.lv = m_lv; e.rv = m_rv; e.bs = m_bs; e.tr = m_tr; e.mx = m_mx;
        sb_q.push_back(e);

        mw_done = 1'b1;
        repeat (8) tick();
        mw_done = 1'b0;
        repeat (12) tick();
        check_eq("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Output monitor: pops one expectation per pulse, then checks attenuation and pulse width
    always @(negedge clk32) begin
        exp_t e;
        if (atten_due) begin
            atten_due = 1'b0;
            check_eq("atten_l", 32'(atten_l), 32'(exp_al));
            check_eq("atten_r", 32'(atten_r), 32'(exp_ar));
            check_eq("pulse_width", 32'({cmd_valid, cmd_err}), 32'd0);
        end else if (cmd_valid || cmd_err) begin
            check_eq("pulse_excl", 32'(cmd_valid & cmd_err), 32'd0);
            check_eq("expected_pulse", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("cmd_valid", 32'(cmd_valid), 32'(!e.err));
                check_eq("cmd_err",   32'(cmd_err),   32'(e.err));
                check_eq("master_vol", 32'(master_vol), 32'(e.mv));
                check_eq("left_vol",   32'(left_vol),   32'(e.lv));
                check_eq("right_vol",  32'(right_vol),  32'(e.rv));
                check_eq("bass",       32'(bass),       32'(e.bs));
                check_eq("treble",     32'(treble),     32'(e.tr));
                check_eq("mix",        32'(mix),        32'(e.mx));
                exp_al    = model_atten(e.mv, e.lv);
                exp_ar    = model_atten(e.mv, e.rv);
                atten_due = 1'b1;
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (5) tick();
        check_reset_state("rst");
        reset = 1'b0;
        repeat (3) tick();
        check_reset_state("post_rst");

        send(16'h04E8, 16'h07FF, -1);   // master 40
        send(16'h04DE, 16'h07FF, -1);   // master 30
        send(16'h04F2, 16'h07FF, -1);   // master 50 saturates to 40
        send(16'h0540, 16'h07FF, -1);   // left 0
        send(16'h04C0, 16'h07FF, -1);   // master 0
        send(16'h044C, 16'h07FF, -1);   // bass 12
        send(16'h0402, 16'h07FF, -1);   // mix 2
        send(16'h048F, 16'h07FF, -1);   // treble 15 saturates to 12
        send(16'h0505, 16'h07FF, -1);   // right 5
        send(16'h02E8, 16'h07FF, -1);   // address 01
        send(16'h04E8, 16'h03FF, -1);   // only 10 bits
        send(16'h0580, 16'h07FF, -1);   // function 110
        send(16'h0000, 16'h0000, -1);   // done without data
        send(16'hFFFF, 16'hFFFF, -1);   // overlong, count saturates
        send(16'h0994, 16'h0FBF, -1);   // gapped mask, master 20

        send(16'h0554, 16'h07FF, 5);
        check_reset_state("abort");
        send(16'h0554, 16'h07FF, -1);
        check_eq("final_left", 32'(left_vol), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
